// File: rtl/prio_pkg.sv
// prio_pkg: shared scan-state enum and priority-order constants for the priority scan encoder
package prio_pkg;
  typedef enum logic {ST_IDLE, ST_SCAN} state_t;
  localparam bit PRIO_HIGH_FIRST = 1'b1;
  localparam bit PRIO_LOW_FIRST = 1'b0;
endpackage

// File: rtl/prio_enc_n.sv
// prio_enc_n: combinational find-first encoder; d vector in, q = highest (HIGH_FIRST) or lowest set index, v = any bit set
module prio_enc_n import prio_pkg::*; #(
  parameter int N = 8,
  parameter bit HIGH_FIRST = PRIO_HIGH_FIRST,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] d,
  output logic [W-1:0] q,
  output logic         v
);
  always_comb begin
    q = '0;
    for (int i = 0; i < N; i++) begin
      if (d[HIGH_FIRST ? i : N-1-i]) q = W'(HIGH_FIRST ? i : N-1-i);
    end
  end
  assign v = |d;
endmodule

// File: rtl/prio_scan_enc.sv
// prio_scan_enc: accepts in_vec via in_valid/in_ready and emits each set index in priority order as out_idx/out_none/out_last beats via out_valid/out_ready
module prio_scan_enc import prio_pkg::*; #(
  parameter int N = 8,
  parameter bit HIGH_FIRST = PRIO_HIGH_FIRST,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_last
);
  state_t state;
  logic [N-1:0] pending;
  logic [W-1:0] q;
  logic v, scan;
  prio_enc_n #(.N(N), .HIGH_FIRST(HIGH_FIRST)) u_enc (.d(pending), .q(q), .v(v));
  assign scan = state == ST_SCAN;
  assign in_ready = !scan;
  assign out_valid = scan;
  assign out_idx = q;
  assign out_none = scan && !v;
  assign out_last = scan && (pending & (pending - N'(1))) == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pending <= '0;
    end else if (!scan) begin
      if (in_valid) begin
        pending <= in_vec;
        state <= ST_SCAN;
      end
    end else if (out_ready) begin
      pending <= out_last ? '0 : pending & ~(N'(1) << q);
      if (out_last) state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_prio_scan_enc.sv
// tb_prio_scan_enc: table-driven and hand-sequenced checks of prio_scan_enc for N=8 high/low-first and N=16
module tb_prio_scan_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv[3];
  logic [15:0] ivec[3];
  logic ordy[3];
  logic ir[3], ov[3], onone[3], olast[3];
  logic [3:0] oidx[3];
  logic [2:0] idx0, idx1;
  logic [3:0] idx2;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign oidx[0] = {1'b0, idx0};
  assign oidx[1] = {1'b0, idx1};
  assign oidx[2] = idx2;
  prio_scan_enc #(.N(8), .HIGH_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_vec(ivec[0][7:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_idx(idx0), .out_none(onone[0]), .out_last(olast[0]));
  prio_scan_enc #(.N(8), .HIGH_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_vec(ivec[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_idx(idx1), .out_none(onone[1]), .out_last(olast[1]));
  prio_scan_enc #(.N(16), .HIGH_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_vec(ivec[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_idx(idx2), .out_none(onone[2]), .out_last(olast[2]));
  typedef struct {
    int d;
    logic [15:0] v;
    int nb;
    logic [63:0] lst;
    bit none;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  task automatic chk_idle(input int d, input string nm);
    chk({nm, "_valid"}, ov[d], 0);
    chk({nm, "_ready"}, ir[d], 1);
    chk({nm, "_idx"}, oidx[d], 0);
    chk({nm, "_none"}, onone[d], 0);
    chk({nm, "_last"}, olast[d], 0);
  endtask
  task automatic run_vec(input int d, input logic [15:0] v, input int nb, input logic [63:0] lst, input bit none);
    chk("pre_ready", ir[d], 1);
    iv[d] = 1'b1;
    ivec[d] = v;
    ordy[d] = 1'b1;
    @(negedge clk);
    iv[d] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      chk("beat_valid", ov[d], 1);
      chk("beat_idx", oidx[d], int'(lst[4*b +: 4]));
      chk("beat_last", olast[d], int'(b == nb - 1));
      chk("beat_none", onone[d], int'(none));
      @(negedge clk);
    end
    chk("ret_ready", ir[d], 1);
    chk("ret_valid", ov[d], 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ivec[i] = '0;
      ordy[i] = 1'b0;
    end
    tv[0] = '{0, 16'h00A6, 4, 64'h1257, 1'b0};
    tv[1] = '{1, 16'h00A6, 4, 64'h7521, 1'b0};
    tv[2] = '{0, 16'h0000, 1, 64'h0, 1'b1};
    tv[3] = '{1, 16'h0000, 1, 64'h0, 1'b1};
    tv[4] = '{2, 16'h8001, 2, 64'h0F, 1'b0};
    tv[5] = '{0, 16'h0010, 1, 64'h4, 1'b0};
    tv[6] = '{2, 16'hFFFF, 16, 64'h0123456789ABCDEF, 1'b0};
    tv[7] = '{1, 16'h0080, 1, 64'h7, 1'b0};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(tv[i].d, tv[i].v, tv[i].nb, tv[i].lst, tv[i].none);
    iv[0] = 1'b1;
    ivec[0] = 16'h0081;
    ordy[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b1;
    ivec[0] = 16'h00FF;
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid", ov[0], 1);
      chk("bp_idx", oidx[0], 7);
      chk("bp_last", olast[0], 0);
      chk("bp_ready", ir[0], 0);
      @(negedge clk);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("bp_idx7", oidx[0], 7);
    chk("bp_last7", olast[0], 0);
    @(negedge clk);
    chk("bp_idx0", oidx[0], 0);
    chk("bp_last0", olast[0], 1);
    chk("bp_valid0", ov[0], 1);
    @(negedge clk);
    chk_idle(0, "bp_end");
    iv[2] = 1'b1;
    ivec[2] = 16'h8001;
    ordy[2] = 1'b1;
    @(negedge clk);
    iv[2] = 1'b0;
    chk("mr_idx15", oidx[2], 15);
    @(negedge clk);
    chk("mr_idx0", oidx[2], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle(2, "mid_rst");
    @(negedge clk);
    chk_idle(2, "mid_rst2");
    run_vec(2, 16'h0010, 1, 64'h4, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
